// File: rtl/depth_merge_pkg.sv
// depth_merge_pkg: fragment/pixel types, framebuffer word alias and FSM states for depth_merge.
package depth_merge_pkg;

    localparam int COORD_W = 10;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
        logic [7:0] depth;
    } pixel_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        pixel_t             pixel;
    } pixel_info_t;

    typedef pixel_t fb_word_t;

    localparam fb_word_t FB_CLEAR_WORD = '{red: 8'd0, green: 8'd0, blue: 8'd0, depth: 8'hFF};

    typedef enum logic [2:0] {IDLE, READ, CMP, WRITE, CLEAR} depth_merge_state_t;

endpackage

// File: rtl/depth_merge_if.sv
// depth_merge_if: framebuffer port; master is the merge stage, slave is the memory.
interface depth_merge_if import depth_merge_pkg::*; #(
    parameter int ADDR_W = 19
);
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_rd_en;
    fb_word_t          fb_rd_data;
    logic              fb_wr_en;
    fb_word_t          fb_wr_data;

    modport master (output fb_addr, fb_rd_en, fb_wr_en, fb_wr_data, input fb_rd_data);
    modport slave  (input fb_addr, fb_rd_en, fb_wr_en, fb_wr_data, output fb_rd_data);
endinterface

// File: rtl/depth_merge_rr_arbiter.sv
// rr_arbiter: round-robin pick among req; priority starts at the port after the last advanced grant.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] ptr_q, ptr_d, c;

    // scan from the far end so the lowest offset from ptr wins
    always_comb begin
        idx = '0;
        c = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c = IW'((int'(ptr_q) + k) % N);
            if (req[c]) idx = c;
        end
        grant = |req ? N'(1) << idx : '0;
        ptr_d = advance ? IW'((int'(idx) + 1) % N) : ptr_q;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) ptr_q <= '0;
        else ptr_q <= ptr_d;
endmodule

// File: rtl/depth_merge.sv
// depth_merge: captures rasterizer fragments, arbitrates round-robin, depth-tests against the
// framebuffer with a read-compare-write, and sweeps the framebuffer clear between frames.
module depth_merge import depth_merge_pkg::*; #(
    parameter int N_PORTS = 4,
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int ADDR_W  = 19
) (
    input  logic               clock,
    input  logic               reset,
    input  pixel_info_t        data_in [N_PORTS],
    input  logic [N_PORTS-1:0] data_write,
    output logic [N_PORTS-1:0] output_written,
    input  logic               clear_req,
    output logic               clear_busy,
    output logic               busy,
    depth_merge_if.master      fb
);
    localparam int GW = $clog2(N_PORTS);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    depth_merge_state_t state_q, state_d;
    pixel_info_t slot_q [N_PORTS], slot_d [N_PORTS];
    pixel_info_t sel, cur;
    logic [N_PORTS-1:0] pending_q, pending_d, dw_q, cap, rel, grant, g_oh;
    logic [GW-1:0] g_q, g_d, gidx;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d, sel_addr;
    logic rd_en_q, rd_en_d, wr_en_q, wr_en_d, clear_busy_q, clear_busy_d, clear_pend_q, clear_pend_d;
    logic advance, in_range;
    fb_word_t wr_data_q, wr_data_d;

    rr_arbiter #(.N(N_PORTS)) u_arb (
        .clock(clock), .reset(reset), .req(pending_q), .advance(advance), .grant(grant), .idx(gidx)
    );

    assign sel      = slot_q[gidx];
    assign cur      = slot_q[g_q];
    assign g_oh     = N_PORTS'(1) << g_q;
    assign in_range = int'(sel.x) < WIDTH && int'(sel.y) < HEIGHT;
    assign sel_addr = ADDR_W'(sel.y) * ADDR_W'(WIDTH) + ADDR_W'(sel.x);
    assign cap      = data_write & ~dw_q & ~pending_q;

    always_comb begin
        state_d = state_q;
        g_d = g_q;
        fb_addr_d = fb_addr_q;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        wr_data_d = wr_data_q;
        clear_busy_d = clear_busy_q;
        clear_pend_d = clear_pend_q | (clear_req & (state_q != CLEAR));
        advance = 1'b0;
        rel = '0;
        case (state_q)
            IDLE:
                if (clear_pend_q) begin
                    state_d = CLEAR;
                    fb_addr_d = '0;
                    wr_en_d = 1'b1;
                    wr_data_d = FB_CLEAR_WORD;
                    clear_busy_d = 1'b1;
                end else if (|pending_q) begin
                    advance = 1'b1;
                    g_d = gidx;
                    if (in_range) begin
                        fb_addr_d = sel_addr;
                        rd_en_d = 1'b1;
                        state_d = READ;
                    end else rel = grant;
                end
            READ: state_d = CMP;
            // strict less-than: ties keep the stored pixel
            CMP:
                if (cur.pixel.depth < fb.fb_rd_data.depth) begin
                    wr_en_d = 1'b1;
                    wr_data_d = cur.pixel;
                    state_d = WRITE;
                end else begin
                    rel = g_oh;
                    state_d = IDLE;
                end
            WRITE: begin
                rel = g_oh;
                state_d = IDLE;
            end
            CLEAR:
                if (fb_addr_q == LAST) begin
                    clear_busy_d = 1'b0;
                    clear_pend_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    fb_addr_d = fb_addr_q + 1'b1;
                    wr_en_d = 1'b1;
                end
            default: state_d = IDLE;
        endcase
        pending_d = (pending_q & ~rel) | cap;
        for (int i = 0; i < N_PORTS; i++) slot_d[i] = cap[i] ? data_in[i] : slot_q[i];
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            slot_q <= '{default: '0};
            pending_q <= '0;
            dw_q <= '0;
            g_q <= '0;
            fb_addr_q <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            wr_data_q <= '0;
            clear_busy_q <= 1'b0;
            clear_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q <= slot_d;
            pending_q <= pending_d;
            dw_q <= data_write;
            g_q <= g_d;
            fb_addr_q <= fb_addr_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            wr_data_q <= wr_data_d;
            clear_busy_q <= clear_busy_d;
            clear_pend_q <= clear_pend_d;
        end

    assign output_written = ~pending_q;
    assign clear_busy     = clear_busy_q;
    assign busy           = |pending_q | (state_q != IDLE) | clear_pend_q;
    assign fb.fb_addr     = fb_addr_q;
    assign fb.fb_rd_en    = rd_en_q;
    assign fb.fb_wr_en    = wr_en_q;
    assign fb.fb_wr_data  = wr_data_q;
endmodule
